bcd_digit_scanner: RTL
======================

Name: bcd_digit_scanner

Overview:
Time-multiplexed scan controller for a common-segment multi-digit 7-segment display. It holds a packed BCD display word and cycles through digit positions. Each position is presented as a 4-bit BCD code to bcd_to_7segment, together with a one-hot digit enable. It also provides leading-zero blanking, per-digit blinking, and tear-free frame-synchronous updates. Blanked digits are sent as code 4'hF, which the downstream decoder renders as all segments off.

Parameters:
NUM_DIGITS, 8, number of digit positions; index 0 is the least significant (rightmost) digit.
SCAN_DIV, 10000, clock cycles each digit is displayed (dwell time); must be >= 2.
BLINK_DIV, 50, number of complete scan frames per blink half-period; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = scanning runs; 0 = display dark, counters frozen
digits_in  in  4*NUM_DIGITS  packed BCD word; nibble k = digit k
load  in  1  capture digits_in as a pending update
blank_lz  in  1  1 = blank leading zeros
blink_mask  in  NUM_DIGITS  bit k = 1 makes digit k blink
bcd_out  out  4  BCD code to the decoder; 4'hF = blank
digit_sel  out  NUM_DIGITS  one-hot, active-high digit enable
frame_tick  out  1  one-cycle pulse when the digit index wraps to 0

Behaviour:
- Reset state: presc=0, idx=0, disp=0, pend=0, pend_v=0, frame_cnt=0, blink_ph=0. Outputs: bcd_out=4'hF, digit_sel=0, frame_tick=0.
- Scan prescaler (enable=1): presc counts 0..SCAN_DIV-1, then wraps to 0.
- Digit advance: when presc==SCAN_DIV-1, idx advances; it wraps from NUM_DIGITS-1 to 0.
- Wrap cycle (presc==SCAN_DIV-1 and idx==NUM_DIGITS-1):
  - frame_tick=1 on the next cycle (registered).
  - If pend_v=1: disp<=pend and pend_v<=0.
  - frame_cnt increments. When frame_cnt reaches BLINK_DIV-1, it clears to 0 and blink_ph toggles.
- Load handling:
  - load=1: pend<=digits_in, pend_v<=1.
  - Multiple loads within one frame: the last one wins.
  - load on the wrap cycle: disp<=digits_in directly (bypass) and pend_v<=0.
- Output register: bcd_out, digit_sel and frame_tick are registered. Their value at cycle t+1 is a function of the state at cycle t. Latency is 1 cycle.
- Dead cycle: when presc==0, digit_sel=0 and bcd_out=4'hF for that cycle (anti-ghosting).
- Otherwise: digit_sel has bit idx set, and bcd_out is the current digit disp[idx] unless a blanking rule applies:
  - Leading-zero rule: blank_lz=1 and all digits from NUM_DIGITS-1 down to idx are 0 and idx!=0 → 4'hF. Digit 0 is never blanked by this rule, so a value of all zeros displays "0".
  - Blink rule: blink_ph=1 and blink_mask[idx]=1 → 4'hF.
  - Codes 4'hA–4'hE pass through unchanged; the decoder blanks them.
- Blanking is evaluated on the committed disp, never on pend or digits_in.
- enable=0:
  - presc, idx, frame_cnt and blink_ph hold.
  - Outputs go to bcd_out=4'hF, digit_sel=0, frame_tick=0 on the next cycle.
  - load is still accepted into pend but is committed only at the next wrap.
- Reset mid-scan returns everything to the reset state on the next edge; any pending load is discarded.
- Invariant: digit_sel is either zero or one-hot.

Decomposition:
- Shared package seg_pkg:
  - BCD_BLANK = 4'hF
  - BCD_W = 4
  - a digit-index width function clog2(NUM_DIGITS)
- One natural sub-module, scan_prescaler: parameter DIV, ports clk/rst/en. Outputs are the count, a tick at count DIV-1, and a zero flag used for the dead cycle.
- Leading-zero and blink masking stay inline as combinational logic.

Test Plan:
(NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2 for all)
1. Reset, enable=1, load digits_in=16'h1234 → the first frame shows dark, since disp=0 until the wrap commits the load (digit 0 shows "0"). From the second frame: digit_sel sequence 0000,0001×3,0000,0010×3,… with bcd_out 4,3,2,1. frame_tick pulses every 16 cycles.
2. disp=16'h0070, blank_lz=1 → digits 3 and 2 get bcd_out=F, digit 1 gets 7, digit 0 gets 0. With blank_lz=0, digits 3 and 2 show 0.
3. disp=16'h0000, blank_lz=1 → digits 3..1 are F, digit 0 is 0.
4. load 16'h1111, then 16'h2222 within the same frame → the next frame shows 2222 only. A load asserted exactly on the wrap cycle → the value appears in the immediately following frame.
5. blink_mask=4'b0100, disp=16'h5555 → digit 2 shows 5 for 2 frames, then F for 2 frames, repeating. All other digits are always 5.
6. Drop enable mid-digit → the next cycle has digit_sel=0 and bcd_out=F. Re-enable → scanning resumes at the same idx/presc. Assert rst mid-frame → the reset state values appear on the next cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path.
//   BCD_W      : width of one BCD digit code
//   BCD_BLANK  : code the downstream decoder renders with all segments off
//   idx_width  : bits needed to address a digit position (at least 1)
package seg_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

    // What a single output cycle presents to the display
    typedef enum logic [1:0] {
        SLOT_DARK,
        SLOT_DIGIT,
        SLOT_BLANKED
    } slot_kind_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_scanner_if.sv
// Bundle of the scanner's control and display signals.
//   master : drives enable, digits_in, load, blank_lz, blink_mask;
//            observes bcd_out, digit_sel, frame_tick
//   slave  : the scanner itself (mirror image of master)
interface bcd_digit_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    import seg_pkg::*;

    logic                          enable;
    logic [BCD_W*NUM_DIGITS-1:0]   digits_in;
    logic                          load;
    logic                          blank_lz;
    logic [NUM_DIGITS-1:0]         blink_mask;
    logic [BCD_W-1:0]              bcd_out;
    logic [NUM_DIGITS-1:0]         digit_sel;
    logic                          frame_tick;

    modport master (
        output enable, digits_in, load, blank_lz, blink_mask,
        input  bcd_out, digit_sel, frame_tick
    );

    modport slave (
        input  enable, digits_in, load, blank_lz, blink_mask,
        output bcd_out, digit_sel, frame_tick
    );

endinterface

// File: rtl/bcd_digit_scanner_scan_prescaler.sv
// Dwell-time prescaler for the digit scan.
//   clk, rst : clock and synchronous active-high reset
//   en       : count only while high, otherwise hold
//   count    : current position 0..DIV-1
//   tick     : high while enabled and count is DIV-1 (last cycle of a dwell)
//   zero     : high while count is 0 (first cycle of a dwell)
module scan_prescaler #(
    parameter int DIV = 10000,
    parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tick,
    output logic          zero
);

    // Free-running modulo-DIV counter that freezes while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (count == CW'(DIV - 1)) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign tick = en && (count == CW'(DIV - 1));
    assign zero = (count == '0);

endmodule

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
//   clk, rst : clock and synchronous active-high reset
//   sif      : slave side of bcd_digit_scanner_if
//              enable     - run the scan; low forces a dark display and freezes counters
//              digits_in  - packed BCD word, nibble k is digit k (digit 0 rightmost)
//              load       - capture digits_in, shown from the next frame on
//              blank_lz   - suppress leading zeros (digit 0 always shown)
//              blink_mask - digits that blink with the slow blink phase
//              bcd_out    - registered code to the decoder, BCD_BLANK when dark
//              digit_sel  - registered one-hot digit enable, zero when dark
//              frame_tick - registered one-cycle pulse as the scan wraps to digit 0
module bcd_digit_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 10000,
    parameter int BLINK_DIV  = 50
) (
    input  logic clk,
    input  logic rst,
    bcd_digit_scanner_if.slave sif
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DW = BCD_W * NUM_DIGITS;

    logic [PW-1:0]         presc;
    logic                  presc_tick;
    logic                  presc_zero;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         disp;
    logic [DW-1:0]         pend;
    logic                  pend_v;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_ph;
    logic                  wrap;
    logic [BCD_W-1:0]      cur_digit;
    logic [BCD_W-1:0]      shown;
    logic [NUM_DIGITS-1:0] lz_run;
    slot_kind_t            slot;

    scan_prescaler #(
        .DIV (SCAN_DIV),
        .CW  (PW)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (sif.enable),
        .count (presc),
        .tick  (presc_tick),
        .zero  (presc_zero)
    );

    // Last dwell cycle of the last digit: the frame boundary
    assign wrap      = presc_tick && (idx == IW'(NUM_DIGITS - 1));
    assign cur_digit = disp[int'(idx)*BCD_W +: BCD_W];

    // lz_run[k] is set when digit k and every more significant digit are zero
    always_comb begin
        lz_run = '0;
        lz_run[NUM_DIGITS-1] = (disp[DW-1 -: BCD_W] == '0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            lz_run[k] = lz_run[k+1] && (disp[k*BCD_W +: BCD_W] == '0);
        end
    end

    // Decide what the current slot shows; codes A..E pass straight through
    always_comb begin
        shown = cur_digit;
        slot  = SLOT_DIGIT;
        if (presc_zero) begin
            slot = SLOT_DARK;
        end else if ((sif.blank_lz && lz_run[idx] && (idx != '0)) ||
                     (blink_ph && sif.blink_mask[idx])) begin
            slot = SLOT_BLANKED;
        end
        if (slot != SLOT_DIGIT) begin
            shown = BCD_BLANK;
        end
    end

    // Digit index steps once per dwell and wraps after the last digit
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (presc_tick) begin
            if (idx == IW'(NUM_DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Display word: loads are parked in pend and committed at the frame
    // boundary so a frame never mixes old and new digits; a load landing
    // exactly on the boundary goes straight into disp
    always_ff @(posedge clk) begin
        if (rst) begin
            disp   <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
        end else if (sif.load && wrap) begin
            disp   <= sif.digits_in;
            pend_v <= 1'b0;
        end else if (sif.load) begin
            pend   <= sif.digits_in;
            pend_v <= 1'b1;
        end else if (wrap && pend_v) begin
            disp   <= pend;
            pend_v <= 1'b0;
        end
    end

    // Blink phase flips every BLINK_DIV complete frames
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (wrap) begin
            if (frame_cnt == FW'(BLINK_DIV - 1)) begin
                frame_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // Registered display outputs; the first cycle of each dwell is kept
    // dark so the previous digit's segments cannot ghost onto the next one
    always_ff @(posedge clk) begin
        if (rst || !sif.enable) begin
            sif.bcd_out    <= BCD_BLANK;
            sif.digit_sel  <= '0;
            sif.frame_tick <= 1'b0;
        end else begin
            sif.frame_tick <= wrap;
            sif.bcd_out    <= shown;
            if (slot == SLOT_DARK) begin
                sif.digit_sel <= '0;
            end else begin
                sif.digit_sel <= NUM_DIGITS'(1) << idx;
            end
        end
    end

    // The prescaler must never leave its 0..SCAN_DIV-1 range
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(presc) < SCAN_DIV);
        end
    end

endmodule
